axil_mm_reg_slave: RTL and testbench

AXI4-Lite responder that the matrix-multiplier IP exposes on its S00_AXI control port. It holds four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC, and drives them to the compute core. It also emits a one-cycle update strobe per register. It is the slave end of the AXI4-Lite master BFM traffic used by the block-design bench.

---
 rtl/axil_mm_pkg.sv | 31 +++
 rtl/axil_hold_slot.sv | 53 +++++
 rtl/axil_mm_reg_slave.sv | 136 +++++++++++++
 tb/tb_axil_mm_reg_slave.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mm_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axil_mm_pkg: shared constants and byte-strobe merge for the AXI-Lite reg slave
// Rev 1.0
// -----------------------------------------------------------------------------
package axil_mm_pkg;

   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam int         ADDR_LSB  = 2;
   localparam int         NUM_REGS  = 4;

   localparam int REG_CTRL = 0;
   localparam int REG_DIM  = 1;
   localparam int REG_SRC  = 2;
   localparam int REG_DST  = 3;

   typedef logic [1:0] reg_idx_t;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axil_hold_slot.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axil_hold_slot: one-deep valid/ready capture; forwards the live beat when empty
// Rev 1.0
// -----------------------------------------------------------------------------
module axil_hold_slot
   import axil_mm_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             ready_o,
   input  logic             pop_i,
   output logic             avail_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             w_accept;

   assign ready_o  = !full_q;
   assign w_accept = valid_i & !full_q;
   assign avail_o  = full_q | w_accept;
   assign data_o   = full_q ? data_q : data_i;

   // A pop consumes either the held beat or the one arriving this cycle.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (pop_i) begin
         full_d = 1'b0;
      end else if (w_accept) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axil_mm_reg_slave.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axil_mm_reg_slave: AXI4-Lite slave holding four 32-bit matrix-multiplier regs
// Rev 1.0
// -----------------------------------------------------------------------------
module axil_mm_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
   input  logic [2:0]                 S_AXI_AWPROT,
   input  logic                       S_AXI_AWVALID,
   output logic                       S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]      S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
   input  logic                       S_AXI_WVALID,
   output logic                       S_AXI_WREADY,
   output logic [1:0]                 S_AXI_BRESP,
   output logic                       S_AXI_BVALID,
   input  logic                       S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
   input  logic [2:0]                 S_AXI_ARPROT,
   input  logic                       S_AXI_ARVALID,
   output logic                       S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]      S_AXI_RDATA,
   output logic [1:0]                 S_AXI_RRESP,
   output logic                       S_AXI_RVALID,
   input  logic                       S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]     reg_q,
   output logic [NUM_REGS-1:0]        reg_wr_pulse
);

   import axil_mm_pkg::*;

   logic [31:0]         regs_q [NUM_REGS];
   logic [31:0]         regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pulse_q, pulse_d;
   logic                bvalid_q, bvalid_d;
   logic                rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                w_aw_avail, w_w_avail, w_b_free, w_fire, w_ar_hs;
   reg_idx_t            w_aw_idx, w_ar_idx;
   logic [35:0]         w_wbeat;
   logic                w_unused;

   axil_hold_slot #(.WIDTH(2)) u_aw_slot (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .valid_i (S_AXI_AWVALID),
      .data_i  (S_AXI_AWADDR[ADDR_LSB +: 2]),
      .ready_o (S_AXI_AWREADY),
      .pop_i   (w_fire),
      .avail_o (w_aw_avail),
      .data_o  (w_aw_idx)
   );

   axil_hold_slot #(.WIDTH(36)) u_w_slot (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .valid_i (S_AXI_WVALID),
      .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
      .ready_o (S_AXI_WREADY),
      .pop_i   (w_fire),
      .avail_o (w_w_avail),
      .data_o  (w_wbeat)
   );

   assign w_b_free = !bvalid_q | S_AXI_BREADY;
   assign w_fire   = w_aw_avail & w_w_avail & w_b_free;
   assign w_ar_idx = S_AXI_ARADDR[ADDR_LSB +: 2];
   assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;

   // Protection bits and out-of-range address bits have no meaning here.
   assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   always_comb begin
      regs_d   = regs_q;
      pulse_d  = '0;
      bvalid_d = bvalid_q;
      if (w_fire) begin
         regs_d[w_aw_idx]  = apply_wstrb(regs_q[w_aw_idx], w_wbeat[31:0], w_wbeat[35:32]);
         pulse_d[w_aw_idx] = 1'b1;
         bvalid_d          = 1'b1;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   // Reads sample the pre-edge register value, so a same-cycle write is not seen.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      if (w_ar_hs) begin
         rdata_d  = regs_q[w_ar_idx];
         rvalid_d = 1'b1;
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pulse_q  <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         pulse_q  <= pulse_d;
         bvalid_q <= bvalid_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign reg_q[32*g +: 32] = regs_q[g];
      end
   endgenerate

   assign S_AXI_ARREADY = !rvalid_q | S_AXI_RREADY;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign reg_wr_pulse  = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_mm_reg_slave.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_axil_mm_reg_slave: scoreboard bench for the AXI4-Lite register slave
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_axil_mm_reg_slave;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          ARESET;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [127:0]  reg_q;
   logic [3:0]    reg_wr_pulse;

   int            total = 0;
   int            bad   = 0;
   logic [1:0]    exp_b[$];
   logic [31:0]   exp_r[$];
   logic [31:0]   mdl[4];
   int            pulse_cnt[4];

   always #5 clk = ~clk;

   axil_mm_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(4)) dut (
      .ACLK          (clk),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   // Scoreboard consumer: compares every B/R handshake against the queue head.
   always @(negedge clk) begin
      if (!ARESET) begin
         for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(reg_wr_pulse[i]);
         if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", bresp, exp_b.pop_front());
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               chk("rresp", rresp, 2'b00);
               chk("rdata", rdata, exp_r.pop_front());
            end
         end
      end
   end

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0;
      bit w_done  = 0;
      int n = 0;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      exp_b.push_back(2'b00);
      mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
      while (!(aw_done && w_done)) begin
         @(negedge clk);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         @(posedge clk); #1;
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
         n++;
         if (n > 50) begin
            chk("wr_timeout", 1, 0);
            awvalid = 1'b0; wvalid = 1'b0;
            break;
         end
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] a);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      exp_r.push_back(mdl[a[3:2]]);
      forever begin
         @(negedge clk);
         if (arready) begin
            @(posedge clk); #1;
            arvalid = 1'b0;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            chk("rd_timeout", 1, 0);
            arvalid = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_b.size() != 0 || exp_r.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            chk("idle_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   logic [31:0] t1_data[4];
   logic [31:0] old_m;

   initial begin
      t1_data[0] = 32'h0101FFFF; t1_data[1] = 32'hABCD0001;
      t1_data[2] = 32'hDEAD0011; t1_data[3] = 32'hBEEF0011;
      for (int i = 0; i < 4; i++) begin mdl[i] = '0; pulse_cnt[i] = 0; end
      ARESET = 1'b1;
      awaddr = '0; awprot = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b1; araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b1;
      repeat (3) @(posedge clk);
      #1 ARESET = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_regq", reg_q, 0);
      chk("rst_pulse", reg_wr_pulse, 0);
      @(posedge clk); #1;

      // 1: write/read each offset
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
      for (int i = 0; i < 4; i++) begin
         axi_write(AW'(i * 4), t1_data[i], 4'hF);
         wait_idle();
         axi_read(AW'(i * 4));
         wait_idle();
      end
      for (int i = 0; i < 4; i++) chk($sformatf("t1_pulse%0d", i), pulse_cnt[i], 1);
      chk("t1_regq", reg_q, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

      // 2: W arrives three cycles ahead of AW
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
      exp_b.push_back(2'b00);
      mdl[2] = 32'h12345678;
      @(posedge clk); #1 wvalid = 1'b0;
      @(negedge clk);
      chk("t2_wready_held", wready, 0);
      chk("t2_bvalid_early", bvalid, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      awaddr = 8'h08; awvalid = 1'b1;
      @(negedge clk);
      chk("t2_awready", awready, 1);
      @(posedge clk); #1 awvalid = 1'b0;
      @(negedge clk);
      chk("t2_bvalid", bvalid, 1);
      chk("t2_reg2", reg_q[95:64], 32'h12345678);
      chk("t2_wready_free", wready, 1);
      wait_idle();

      // 3: partial strobe
      axi_write(8'h04, 32'hFFFFFFFF, 4'hF);
      axi_write(8'h04, 32'h00000000, 4'b0101);
      wait_idle();
      chk("t3_reg1", reg_q[63:32], 32'hFF00FF00);
      axi_read(8'h04);
      wait_idle();

      // 4: B backpressure holds a second pair in the slots
      bready = 1'b0;
      axi_write(8'h00, 32'h11111111, 4'hF);
      old_m = mdl[1];
      axi_write(8'h04, 32'h22222222, 4'hF);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_awready", awready, 0);
         chk("t4_wready", wready, 0);
         chk("t4_bvalid", bvalid, 1);
         chk("t4_reg1_held", reg_q[63:32], old_m);
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(negedge clk);
      chk("t4_reg0", reg_q[31:0], 32'h11111111);
      @(negedge clk);
      chk("t4_bvalid2", bvalid, 1);
      chk("t4_reg1", reg_q[63:32], 32'h22222222);
      @(negedge clk);
      chk("t4_bvalid_done", bvalid, 0);
      @(posedge clk); #1;
      wait_idle();

      // 5: same-cycle read and write of reg1, then R backpressure
      axi_write(8'h04, 32'h00000001, 4'hF);
      wait_idle();
      rready = 1'b0;
      araddr = 8'h04; arvalid = 1'b1;
      awaddr = 8'h04; awvalid = 1'b1; wdata = 32'hCAFE0000; wstrb = 4'hF; wvalid = 1'b1;
      exp_r.push_back(mdl[1]);
      exp_b.push_back(2'b00);
      mdl[1] = 32'hCAFE0000;
      @(negedge clk);
      chk("t5_ready_all", {arready, awready, wready}, 3'b111);
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("t5_pulse", reg_wr_pulse, 4'b0010);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         chk("t5_rvalid", rvalid, 1);
         chk("t5_rdata_stable", rdata, 32'h00000001);
         chk("t5_arready", arready, 0);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      wait_idle();
      axi_read(8'h04);
      wait_idle();

      // 6: reset with a pending B and a held W beat
      bready = 1'b0;
      axi_write(8'h00, 32'hAAAA5555, 4'hF);
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      chk("t6_wready", wready, 1);
      @(posedge clk); #1 wvalid = 1'b0;
      @(negedge clk);
      chk("t6_bvalid_pend", bvalid, 1);
      chk("t6_w_held", wready, 0);
      @(posedge clk); #1 ARESET = 1'b1;
      exp_b.delete();
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      @(posedge clk); #1 ARESET = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      chk("t6_bvalid_clr", bvalid, 0);
      chk("t6_regq_clr", reg_q, 0);
      chk("t6_wready_clr", wready, 1);
      @(posedge clk); #1;
      axi_write(8'h10, 32'h5A5A0F0F, 4'hF);
      wait_idle();
      chk("t6_alias", reg_q, {96'h0, 32'h5A5A0F0F});
      axi_read(8'h20);
      wait_idle();

      repeat (3) @(posedge clk);
      chk("sb_b_empty", exp_b.size(), 0);
      chk("sb_r_empty", exp_r.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
